// File: rtl/ddr_tx_serializer_if.sv
// Word handshake into the DDR transmit serializer.
// DATA is sampled on a rising edge with VALID && READY.
interface ddr_tx_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             READY;

    modport master (
        output DATA,
        output VALID,
        input  READY
    );

    modport slave (
        input  DATA,
        input  VALID,
        output READY
    );
endinterface

// File: rtl/ddr_tx_serializer.sv
// Parallel-to-pair serializer feeding an ODDR: one bit pair per clock on D1/D2.
// A one-word holding register lets back-to-back words leave with no gap.
module ddr_tx_serializer #(
    parameter int   WIDTH     = 8,
    parameter logic IDLE      = 1'b0,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic                C,
    input  logic                R,
    ddr_tx_serializer_if.slave  bus,
    output logic                D1,
    output logic                D2,
    output logic                ACTIVE,
    output logic                BUSY
);

    localparam int BEATS = WIDTH / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("ddr_tx_serializer: WIDTH must be even and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             sr_active, sr_active_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last;
    logic             load_now;
    logic             xfer;

    // SR always shifts toward its MSB; LSB-first words are reversed on load.
    function automatic logic [WIDTH-1:0] order(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = MSB_FIRST ? w[i] : w[WIDTH-1-i];
        end
        return r;
    endfunction

    assign last      = (cnt == LAST);
    assign load_now  = hold_full && (!sr_active || last);
    assign bus.READY = !R && (!hold_full || load_now);
    assign xfer      = bus.VALID && bus.READY;
    assign BUSY      = hold_full || sr_active;

    always_comb begin
        hold_n      = hold;
        hold_full_n = hold_full;
        sr_n        = sr;
        sr_active_n = sr_active;
        cnt_n       = cnt;

        if (load_now) begin
            sr_n        = order(hold);
            sr_active_n = 1'b1;
            cnt_n       = '0;
            hold_full_n = 1'b0;
        end else if (sr_active) begin
            if (last) begin
                sr_active_n = 1'b0;
                cnt_n       = '0;
            end else begin
                cnt_n = cnt + CW'(1);
                sr_n  = sr << 2;
            end
        end

        if (xfer) begin
            hold_n      = bus.DATA;
            hold_full_n = 1'b1;
        end
    end

    // Output flops are loaded from next state so beat 0 appears at the load edge.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            hold      <= '0;
            hold_full <= 1'b0;
            sr        <= '0;
            sr_active <= 1'b0;
            cnt       <= '0;
            D1        <= IDLE;
            D2        <= IDLE;
            ACTIVE    <= 1'b0;
        end else begin
            hold      <= hold_n;
            hold_full <= hold_full_n;
            sr        <= sr_n;
            sr_active <= sr_active_n;
            cnt       <= cnt_n;
            D1        <= sr_active_n ? sr_n[WIDTH-1] : IDLE;
            D2        <= sr_active_n ? sr_n[WIDTH-2] : IDLE;
            ACTIVE    <= sr_active_n;
        end
    end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: four parameterisations sharing one clock/reset,
// directed scenarios plus a random run against a word-queue reference model.
module tb_ddr_tx_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] data [4];
    logic       vld  [4];
    logic       rdy  [4];
    logic       d1   [4];
    logic       d2   [4];
    logic       act  [4];
    logic       busy [4];

    // Per-instance configuration: width, bit order, idle level.
    int wcfg [4] = '{8, 8, 2, 8};
    bit mcfg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit icfg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    int n_chk  = 0;
    int n_fail = 0;

    ddr_tx_serializer_if #(.WIDTH(8)) i0 ();
    ddr_tx_serializer_if #(.WIDTH(8)) i1 ();
    ddr_tx_serializer_if #(.WIDTH(2)) i2 ();
    ddr_tx_serializer_if #(.WIDTH(8)) i3 ();

    assign i0.DATA  = data[0];
    assign i1.DATA  = data[1];
    assign i2.DATA  = data[2][1:0];
    assign i3.DATA  = data[3];
    assign i0.VALID = vld[0];
    assign i1.VALID = vld[1];
    assign i2.VALID = vld[2];
    assign i3.VALID = vld[3];
    assign rdy[0]   = i0.READY;
    assign rdy[1]   = i1.READY;
    assign rdy[2]   = i2.READY;
    assign rdy[3]   = i3.READY;

    ddr_tx_serializer #(.WIDTH(8), .IDLE(1'b0), .MSB_FIRST(1'b1)) u0 (
        .C(clk), .R(rst), .bus(i0.slave),
        .D1(d1[0]), .D2(d2[0]), .ACTIVE(act[0]), .BUSY(busy[0])
    );
    ddr_tx_serializer #(.WIDTH(8), .IDLE(1'b0), .MSB_FIRST(1'b0)) u1 (
        .C(clk), .R(rst), .bus(i1.slave),
        .D1(d1[1]), .D2(d2[1]), .ACTIVE(act[1]), .BUSY(busy[1])
    );
    ddr_tx_serializer #(.WIDTH(2), .IDLE(1'b0), .MSB_FIRST(1'b1)) u2 (
        .C(clk), .R(rst), .bus(i2.slave),
        .D1(d1[2]), .D2(d2[2]), .ACTIVE(act[2]), .BUSY(busy[2])
    );
    ddr_tx_serializer #(.WIDTH(8), .IDLE(1'b1), .MSB_FIRST(1'b1)) u3 (
        .C(clk), .R(rst), .bus(i3.slave),
        .D1(d1[3]), .D2(d2[3]), .ACTIVE(act[3]), .BUSY(busy[3])
    );

    // Every pair instance 0 puts on the wire while ACTIVE.
    logic [1:0] obs0 [$];
    always @(negedge clk) begin
        if (act[0]) obs0.push_back({d1[0], d2[0]});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: pair k of a word, straight from the bit-numbering rule.
    function automatic logic [1:0] pair(input logic [7:0] w, input int width,
                                        input bit msb, input int k);
        if (msb) return {w[width-1-2*k], w[width-2-2*k]};
        return {w[2*k], w[2*k+1]};
    endfunction

    function automatic logic [1:0] idle2(input int id);
        return {icfg[id], icfg[id]};
    endfunction

    task automatic single(input int id, input logic [7:0] w, input string tag);
        data[id] = w;
        vld[id]  = 1'b1;
        chk({tag, "_rdy"}, 8'(rdy[id]), 8'd1);
        cyc();
        vld[id] = 1'b0;
        chk({tag, "_lat_act"}, 8'(act[id]), 8'd0);
        chk({tag, "_lat_d"}, 8'({d1[id], d2[id]}), 8'(idle2(id)));
        cyc();
        for (int k = 0; k < wcfg[id] / 2; k++) begin
            chk($sformatf("%s_act%0d", tag, k), 8'(act[id]), 8'd1);
            chk($sformatf("%s_pair%0d", tag, k), 8'({d1[id], d2[id]}),
                8'(pair(w, wcfg[id], mcfg[id], k)));
            cyc();
        end
        chk({tag, "_end_act"}, 8'(act[id]), 8'd0);
        chk({tag, "_end_d"}, 8'({d1[id], d2[id]}), 8'(idle2(id)));
        chk({tag, "_end_busy"}, 8'(busy[id]), 8'd0);
    endtask

    task automatic drain(input int id, input string tag);
        for (int t = 0; t < 40 && busy[id]; t++) cyc();
        chk({tag, "_drain"}, 8'(busy[id]), 8'd0);
    endtask

    task automatic cmp_stream(input logic [7:0] words [$], input string tag);
        int nb;
        nb = words.size() * 4;
        chk({tag, "_count"}, 8'(obs0.size() == nb), 8'd1);
        for (int j = 0; j < nb && j < obs0.size(); j++) begin
            chk($sformatf("%s_beat%0d", tag, j), 8'(obs0[j]),
                8'(pair(words[j/4], 8, 1'b1, j % 4)));
        end
    endtask

    initial begin
        logic [7:0] wq [$];
        logic [7:0] w2 [5];

        for (int i = 0; i < 4; i++) begin
            data[i] = '0;
            vld[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (2) cyc();

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_rdy%0d", i), 8'(rdy[i]), 8'd0);
            chk($sformatf("rst_act%0d", i), 8'(act[i]), 8'd0);
            chk($sformatf("rst_busy%0d", i), 8'(busy[i]), 8'd0);
            chk($sformatf("rst_d%0d", i), 8'({d1[i], d2[i]}), 8'(idle2(i)));
        end
        rst = 1'b0;
        #1;
        chk("rel_rdy", 8'(rdy[0]), 8'd1);

        single(0, 8'hA5, "a5");

        // Back-to-back with VALID held high.
        wq = '{8'hF0, 8'h0F};
        data[0] = 8'hF0;
        vld[0]  = 1'b1;
        chk("b2b_rdy0", 8'(rdy[0]), 8'd1);
        cyc();
        data[0] = 8'h0F;
        chk("b2b_rdy1", 8'(rdy[0]), 8'd1);
        cyc();
        vld[0] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("b2b_act%0d", j), 8'(act[0]), 8'd1);
            chk($sformatf("b2b_pair%0d", j), 8'({d1[0], d2[0]}),
                8'(pair(wq[j/4], 8, 1'b1, j % 4)));
            if (j == 1 || j == 2) chk("b2b_rdy_low", 8'(rdy[0]), 8'd0);
            if (j == 3) chk("b2b_rdy_high", 8'(rdy[0]), 8'd1);
            cyc();
        end
        chk("b2b_end_act", 8'(act[0]), 8'd0);

        single(1, 8'h01, "lsb");

        // WIDTH=2 streaming: one word per cycle.
        w2 = '{8'h2, 8'h1, 8'h3, 8'h0, 8'h2};
        for (int i = 0; i < 5; i++) begin
            data[2] = w2[i];
            vld[2]  = 1'b1;
            chk($sformatf("w2_rdy%0d", i), 8'(rdy[2]), 8'd1);
            if (i == 1) chk("w2_lat", 8'(act[2]), 8'd0);
            if (i >= 2) begin
                chk($sformatf("w2_act%0d", i - 2), 8'(act[2]), 8'd1);
                chk($sformatf("w2_pair%0d", i - 2), 8'({d1[2], d2[2]}),
                    8'(pair(w2[i-2], 2, 1'b1, 0)));
            end
            cyc();
        end
        vld[2] = 1'b0;
        for (int i = 3; i < 5; i++) begin
            chk($sformatf("w2_act%0d", i), 8'(act[2]), 8'd1);
            chk($sformatf("w2_pair%0d", i), 8'({d1[2], d2[2]}),
                8'(pair(w2[i], 2, 1'b1, 0)));
            chk($sformatf("w2_rdyt%0d", i), 8'(rdy[2]), 8'd1);
            cyc();
        end
        chk("w2_end_act", 8'(act[2]), 8'd0);

        // Backpressure: 3C is replaced by FF before READY returns.
        obs0.delete();
        data[0] = 8'h55;
        vld[0]  = 1'b1;
        cyc();
        data[0] = 8'hAA;
        cyc();
        data[0] = 8'h3C;
        chk("bp_rdy_low", 8'(rdy[0]), 8'd0);
        cyc();
        data[0] = 8'hFF;
        for (int t = 0; t < 10 && !rdy[0]; t++) cyc();
        chk("bp_rdy_rise", 8'(rdy[0]), 8'd1);
        cyc();
        vld[0] = 1'b0;
        drain(0, "bp");
        cyc();
        cmp_stream('{8'h55, 8'hAA, 8'hFF}, "bp");

        // Asynchronous reset during beat 2 with IDLE=1.
        data[3] = 8'hA5;
        vld[3]  = 1'b1;
        cyc();
        vld[3] = 1'b0;
        repeat (3) cyc();
        chk("mid_beat2", 8'({d1[3], d2[3]}), 8'(pair(8'hA5, 8, 1'b1, 2)));
        rst = 1'b1;
        #1;
        chk("mid_rst_d", 8'({d1[3], d2[3]}), 8'h3);
        chk("mid_rst_act", 8'(act[3]), 8'd0);
        chk("mid_rst_busy", 8'(busy[3]), 8'd0);
        chk("mid_rst_rdy", 8'(rdy[3]), 8'd0);
        cyc();
        rst = 1'b0;
        #1;
        single(3, 8'h00, "post");

        // Random traffic on instance 0 against a queue of accepted words.
        obs0.delete();
        wq.delete();
        for (int c = 0; c < 300; c++) begin
            vld[0]  = ($urandom_range(0, 3) != 0);
            data[0] = 8'($urandom);
            if (vld[0] && rdy[0]) wq.push_back(data[0]);
            cyc();
        end
        vld[0] = 1'b0;
        drain(0, "rnd");
        cyc();
        chk("rnd_some", 8'(wq.size() > 10), 8'd1);
        cmp_stream(wq, "rnd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
